// File: rtl/apb_master_bridge.sv
// ============================================================================
// Module   : apb_master_bridge
// Brief    : Valid/ready command channel to APB4 requester (PSTRB/PPROT).
//            Optional access watchdog enabled by defining APB_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module apb_master_bridge #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                  pclk_i,
    input  logic                  presetn_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_write_i,
    input  logic [ADDR_W-1:0]     cmd_addr_i,
    input  logic [DATA_W-1:0]     cmd_wdata_i,
    input  logic [DATA_W/8-1:0]   cmd_strb_i,
    input  logic [2:0]            cmd_prot_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_W-1:0]     rsp_rdata_o,
    output logic                  rsp_slverr_o,
    output logic                  rsp_timeout_o,
    output logic [ADDR_W-1:0]     paddr_o,
    output logic                  psel_o,
    output logic                  penable_o,
    output logic                  pwrite_o,
    output logic [DATA_W-1:0]     pwdata_o,
    output logic [DATA_W/8-1:0]   pstrb_o,
    output logic [2:0]            pprot_o,
    input  logic                  pready_i,
    input  logic [DATA_W-1:0]     prdata_i,
    input  logic                  pslverr_i
);

    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   paddr_q;
    logic                psel_q;
    logic                penable_q;
    logic                pwrite_q;
    logic [DATA_W-1:0]   pwdata_q;
    logic [STRB_W-1:0]   pstrb_q;
    logic [2:0]          pprot_q;
    logic                rsp_valid_q;
    logic [DATA_W-1:0]   rsp_rdata_q;
    logic                rsp_slverr_q;
    logic                tmo_hit;

`ifdef APB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CNT_W-1:0] tmo_cnt_q;
    logic             rsp_timeout_q;

    assign tmo_hit = (tmo_cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    // Counts ACCESS cycles spent waiting; pready in the limit cycle still wins.
    always_ff @(posedge pclk_i or negedge presetn_i) begin
        if (!presetn_i) begin
            tmo_cnt_q     <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            if (state_q == S_SETUP) begin
                tmo_cnt_q <= '0;
            end else if (state_q == S_ACCESS && !pready_i && !tmo_hit) begin
                tmo_cnt_q <= tmo_cnt_q + 1'b1;
            end

            if (state_q == S_ACCESS && !pready_i && tmo_hit) begin
                rsp_timeout_q <= 1'b1;
            end else if (state_q == S_RESP && rsp_ready_i) begin
                rsp_timeout_q <= 1'b0;
            end
        end
    end

    assign rsp_timeout_o = rsp_timeout_q;
`else
    // Watchdog absent: the limit parameter is accepted but never fires.
    assign tmo_hit       = 1'b0 && (TIMEOUT_CYC > 0);
    assign rsp_timeout_o = 1'b0;
`endif

    always_ff @(posedge pclk_i or negedge presetn_i) begin
        if (!presetn_i) begin
            state_q      <= S_IDLE;
            paddr_q      <= '0;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            pwrite_q     <= 1'b0;
            pwdata_q     <= '0;
            pstrb_q      <= '0;
            pprot_q      <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= '0;
            rsp_slverr_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid_i) begin
                        paddr_q  <= cmd_addr_i;
                        pwrite_q <= cmd_write_i;
                        pwdata_q <= cmd_wdata_i;
                        pstrb_q  <= cmd_write_i ? cmd_strb_i : '0;
                        pprot_q  <= cmd_prot_i;
                        psel_q   <= 1'b1;
                        state_q  <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (pready_i) begin
                        psel_q       <= 1'b0;
                        penable_q    <= 1'b0;
                        rsp_rdata_q  <= pwrite_q ? '0 : prdata_i;
                        rsp_slverr_q <= pslverr_i;
                        rsp_valid_q  <= 1'b1;
                        state_q      <= S_RESP;
                    end else if (tmo_hit) begin
                        psel_q       <= 1'b0;
                        penable_q    <= 1'b0;
                        rsp_rdata_q  <= '0;
                        rsp_slverr_q <= 1'b1;
                        rsp_valid_q  <= 1'b1;
                        state_q      <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Gated by reset so the channel reads not-ready while presetn is low.
    assign cmd_ready_o  = (state_q == S_IDLE) && presetn_i;

    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_rdata_o  = rsp_rdata_q;
    assign rsp_slverr_o = rsp_slverr_q;
    assign paddr_o      = paddr_q;
    assign psel_o       = psel_q;
    assign penable_o    = penable_q;
    assign pwrite_o     = pwrite_q;
    assign pwdata_o     = pwdata_q;
    assign pstrb_o      = pstrb_q;
    assign pprot_o      = pprot_q;

endmodule

`default_nettype wire

// File: tb/tb_apb_master_bridge.sv
// ============================================================================
// Module   : tb_apb_master_bridge
// Brief    : Scoreboard bench for apb_master_bridge with a memory-backed APB slave.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_apb_master_bridge;

`ifdef APB_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 256;
`endif
    localparam int ERR_IDX = 13;

    logic        clk;
    logic        presetn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_strb;
    logic [2:0]  cmd_prot;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_slverr, rsp_timeout;
    logic [31:0] paddr, pwdata, prdata;
    logic        psel, penable, pwrite, pready, pslverr;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;

    apb_master_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TMO)) dut (
        .pclk_i(clk), .presetn_i(presetn),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
        .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata), .cmd_strb_i(cmd_strb),
        .cmd_prot_i(cmd_prot),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
        .rsp_slverr_o(rsp_slverr), .rsp_timeout_o(rsp_timeout),
        .paddr_o(paddr), .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite),
        .pwdata_o(pwdata), .pstrb_o(pstrb), .pprot_o(pprot),
        .pready_i(pready), .prdata_i(prdata), .pslverr_i(pslverr)
    );

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [2:0]  prot;
        int          waits;
    } apb_t;

    typedef struct {
        logic [31:0] rdata;
        logic        slverr;
        logic        tmo;
        int          hs;
        int          lat;
    } rsp_t;

    apb_t        apb_q[$];
    rsp_t        rsp_q[$];
    int          wait_q[$];
    logic [31:0] model_mem [16];
    logic [31:0] slave_mem [16];
    int          checks = 0;
    int          passes = 0;
    int          cyc = 0;
    int          hold_req = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    function automatic bit is_err(input logic [31:0] a);
        return a[5:2] == 4'(ERR_IDX);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] st);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (st[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    // Issue one command; the expected APB transfer and response are predicted at handshake.
    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] st, input logic [2:0] pr, input int waits);
        apb_t a;
        rsp_t r;
        int   n = 0;
        bit   ok = 0;
        @(posedge clk) #1;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr;
        cmd_wdata = wd; cmd_strb = st; cmd_prot = pr;
        while (n < 500) begin
            @(negedge clk);
            if (cmd_ready) begin ok = 1; break; end
            n++;
        end
        chk("cmd_handshake", ok, 1'b1);
        if (ok) begin
            a.wr = wr; a.addr = addr; a.wdata = wd; a.strb = st; a.prot = pr; a.waits = waits;
            apb_q.push_back(a);
            wait_q.push_back(waits);
            r.hs  = cyc;
            r.tmo = 1'b0;
            if (waits < 0) begin
                r.rdata = '0; r.slverr = 1'b1; r.tmo = 1'b1; r.lat = 3 + TMO - 1;
            end else begin
                r.lat    = 3 + waits;
                r.slverr = is_err(addr);
                r.rdata  = wr ? 32'h0 : model_mem[addr[5:2]];
                if (wr && !is_err(addr)) model_mem[addr[5:2]] = merge(model_mem[addr[5:2]], wd, st);
            end
            rsp_q.push_back(r);
        end
        @(posedge clk) #1;
        cmd_valid = 1'b0; cmd_write = $urandom_range(0, 1); cmd_addr = $urandom;
        cmd_wdata = $urandom; cmd_strb = 4'($urandom); cmd_prot = 3'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while ((rsp_q.size() != 0 || rsp_valid) && n < 400) begin
            @(negedge clk); n++;
        end
        chk("drain_rsp_q", rsp_q.size(), 0);
        chk("drain_apb_q", apb_q.size(), 0);
    endtask

    // APB slave: wait states come from the command stream, data from its own memory.
    initial begin
        int wcnt = 0;
        pready = 1'b0; prdata = '0; pslverr = 1'b0;
        forever begin
            @(negedge clk);
            if (!presetn) begin
                pready = $urandom_range(0, 1); pslverr = $urandom_range(0, 1);
            end else if (psel && !penable) begin
                wcnt = (wait_q.size() != 0) ? wait_q.pop_front() : 0;
                pready = $urandom_range(0, 1); pslverr = $urandom_range(0, 1); prdata = $urandom;
            end else if (psel && penable) begin
                if (wcnt == 0) begin
                    pready  = 1'b1;
                    pslverr = is_err(paddr);
                    prdata  = pwrite ? $urandom : slave_mem[paddr[5:2]];
                    if (pwrite && !is_err(paddr))
                        slave_mem[paddr[5:2]] = merge(slave_mem[paddr[5:2]], pwdata, pstrb);
                end else begin
                    if (wcnt > 0) wcnt--;
                    pready = 1'b0; pslverr = $urandom_range(0, 1); prdata = $urandom;
                end
            end else begin
                pready = $urandom_range(0, 1); pslverr = $urandom_range(0, 1); prdata = $urandom;
            end
        end
    end

    // APB monitor: transfer contents, stability and ACCESS length.
    initial begin
        apb_t cur;
        bit   in_xfer = 0;
        int   pen_cnt = 0;
        forever begin
            @(negedge clk);
            if (!presetn) begin
                in_xfer = 0;
            end else begin
                chk("penable_implies_psel", penable & ~psel, 1'b0);
                if (psel && !penable) begin
                    chk("apb_expected", apb_q.size() != 0, 1'b1);
                    if (apb_q.size() != 0) begin
                        cur = apb_q.pop_front();
                        chk("setup_paddr", paddr, cur.addr);
                        chk("setup_pwrite", pwrite, cur.wr);
                        chk("setup_pwdata", pwdata, cur.wdata);
                        chk("setup_pstrb", pstrb, cur.wr ? cur.strb : 4'h0);
                        chk("setup_pprot", pprot, cur.prot);
                        in_xfer = 1; pen_cnt = 0;
                    end
                end else if (in_xfer) begin
                    if (penable) begin
                        pen_cnt++;
                        chk("access_stable", {paddr, pwrite, pwdata, pstrb, pprot},
                            {cur.addr, cur.wr, cur.wdata, cur.wr ? cur.strb : 4'h0, cur.prot});
                    end
                    if (!psel) begin
                        in_xfer = 0;
                        chk("access_cycles", pen_cnt, (cur.waits < 0) ? TMO : cur.waits + 1);
                    end
                end
            end
        end
    end

    // Response monitor: payload, latency, stability under backpressure.
    initial begin
        rsp_t e;
        bit   holding = 0;
        int   hold_cnt = 0;
        logic [33:0] held = '0;
        rsp_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (!presetn) begin
                holding = 0; hold_cnt = 0; rsp_ready = 1'b0;
            end else if (rsp_valid) begin
                chk("cmd_ready_low_in_resp", cmd_ready, 1'b0);
                chk("psel_low_in_resp", psel, 1'b0);
                if (!holding) begin
                    chk("rsp_expected", rsp_q.size() != 0, 1'b1);
                    if (rsp_q.size() != 0) begin
                        e = rsp_q.pop_front();
                        chk("rsp_rdata", rsp_rdata, e.rdata);
                        chk("rsp_slverr", rsp_slverr, e.slverr);
                        chk("rsp_timeout", rsp_timeout, e.tmo);
                        chk("rsp_latency", cyc - e.hs, e.lat);
                    end
                    held = {rsp_rdata, rsp_slverr, rsp_timeout};
                    holding = 1;
                    hold_cnt = hold_req; hold_req = 0;
                end else begin
                    chk("rsp_stable", {rsp_rdata, rsp_slverr, rsp_timeout}, held);
                end
                if (hold_cnt > 0) begin
                    rsp_ready = 1'b0; hold_cnt--;
                end else begin
                    rsp_ready = ($urandom_range(0, 3) != 0);
                end
                if (rsp_ready) holding = 0;
            end else begin
                chk("rsp_valid_held", holding, 1'b0);
                holding = 0;
                rsp_ready = $urandom_range(0, 1);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $display("%0d/%0d checks passed", passes, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit ok;
        for (int i = 0; i < 16; i++) begin model_mem[i] = '0; slave_mem[i] = '0; end
        model_mem[8] = 32'hDEAD_BEEF;
        slave_mem[8] = 32'hDEAD_BEEF;
        presetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_wdata = '0; cmd_strb = '0; cmd_prot = '0;

        repeat (3) @(negedge clk);
        chk("reset_cmd_ready", cmd_ready, 1'b0);
        chk("reset_psel_penable", {psel, penable}, 2'b00);
        chk("reset_rsp", {rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout}, '0);
        chk("reset_apb_bus", {paddr, pwrite, pwdata, pstrb, pprot}, '0);
        #2 presetn = 1'b1;
        #1 chk("cmd_ready_after_release", cmd_ready, 1'b1);

        issue(1'b1, 32'h10, 32'hA5A5_0001, 4'hF, 3'd0, 0);
        issue(1'b0, 32'h20, 32'h1234_5678, 4'hF, 3'd2, 5);
        issue(1'b1, 32'h34, 32'h5555_AAAA, 4'hF, 3'd1, 0);
        issue(1'b0, 32'h20, 32'h0, 4'h3, 3'd1, 1);
        hold_req = 10;
        issue(1'b0, 32'h10, 32'h0, 4'h0, 3'd7, 0);
        drain();

        issue(1'b0, 32'h28, 32'h0, 4'h0, 3'd0, 20);
        n = 0; ok = 0;
        while (n < 50) begin
            @(negedge clk);
            if (penable) begin ok = 1; break; end
            n++;
        end
        chk("reached_access", ok, 1'b1);
        #2 presetn = 1'b0;
        #1 chk("async_reset_outputs", {psel, penable, rsp_valid, cmd_ready}, 4'b0000);
        repeat (2) @(negedge clk);
        apb_q.delete(); rsp_q.delete(); wait_q.delete();
        #2 presetn = 1'b1;
        #1 chk("cmd_ready_cycle_after_reset", cmd_ready, 1'b1);

        for (int i = 0; i < 150; i++) begin
            logic [31:0] a;
            a = ($urandom & 32'hFFFF_FFC0) | (32'($urandom_range(0, 15)) << 2);
            issue(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom), 3'($urandom),
                  $urandom_range(0, 4));
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        drain();

`ifdef APB_TIMEOUT_EN
        issue(1'b0, 32'h08, 32'h0, 4'h0, 3'd3, -1);
        issue(1'b0, 32'h20, 32'h0, 4'h0, 3'd0, 2);
        drain();
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

`default_nettype wire
